// File: rtl/nic_defs.sv
// Shared definitions for the CPU-NIC TX scheduling path:
// scheduler states, burst kinds, CCI-P line-length codes, helpers.
package nic_defs;

  localparam int LMAX_CCIP_BATCH = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2,
    S_GAP   = 2'd3
  } TxSchedState;

  typedef enum logic {
    BURST_FULL  = 1'b0,
    BURST_FLUSH = 1'b1
  } TxBurstType;

  typedef enum logic [1:0] {
    eCL_LEN_1 = 2'b00,
    eCL_LEN_2 = 2'b01,
    eCL_LEN_4 = 2'b11
  } t_ccip_clLen;

  function automatic int occ_width(input int lfifo_depth);
    return lfifo_depth + 1;
  endfunction

  function automatic t_ccip_clLen cl_len_of(input logic [1:0] bsz);
    t_ccip_clLen r;
    unique case (bsz)
      2'd0:    r = eCL_LEN_1;
      2'd1:    r = eCL_LEN_2;
      default: r = eCL_LEN_4;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/flow_age_tracker.sv
// Per-flow age counter: saturating cycle count since the flow was last
// empty/served. Ports: clk, resetn, clr, flush_timeout in; expired out.
module flow_age_tracker #(
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr,
  input  logic [TIMEOUT_W-1:0] flush_timeout,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] age_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      age_q <= '0;
    end else if (clr) begin
      age_q <= '0;
    end else if (age_q != '1) begin
      age_q <= age_q + TIMEOUT_W'(1);
    end
  end

  // A zero threshold disables flushing entirely.
  assign expired = (flush_timeout != '0) &&
                   (age_q >= flush_timeout);

endmodule

// File: rtl/ccip_tx_flow_scheduler.sv
// Round-robin batch scheduler: scans flow FIFO fill levels, issues
// full-batch or age-flush pop bursts, gated by CCI-P TX almost-full.
// In: clk, resetn, start, number_of_flows, l_batch_size, flush_timeout,
//     ccip_almost_full, flow_occupancy.
// Out: pop_en, grant_*, busy, stat_flush_cnt.
module ccip_tx_flow_scheduler
  import nic_defs::*;
#(
  parameter int LMAX_NUM_OF_FLOWS = 1,
  parameter int LFIFO_DEPTH       = 3,
  parameter int TIMEOUT_W         = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         start,
  input  logic [LMAX_NUM_OF_FLOWS-1:0] number_of_flows,
  input  logic [LMAX_CCIP_BATCH-1:0]   l_batch_size,
  input  logic [TIMEOUT_W-1:0]         flush_timeout,
  input  logic                         ccip_almost_full,
  input  logic [(2**LMAX_NUM_OF_FLOWS)*(LFIFO_DEPTH+1)-1:0] flow_occupancy,
  output logic [(2**LMAX_NUM_OF_FLOWS)-1:0] pop_en,
  output logic                         grant_valid,
  output logic [LMAX_NUM_OF_FLOWS-1:0] grant_flow_id,
  output logic [1:0]                   grant_cl_len,
  output logic                         grant_sop,
  output logic                         grant_eop,
  output logic                         busy,
  output logic [31:0]                  stat_flush_cnt
);

  localparam int MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS;
  localparam int OW        = occ_width(LFIFO_DEPTH);
  localparam int FW        = LMAX_NUM_OF_FLOWS;

  TxSchedState state_q, state_d;
  TxBurstType  burst_q, burst_d;
  t_ccip_clLen len_q, len_d, cl_d;

  logic [FW-1:0]        rr_q, rr_d;
  logic [FW-1:0]        flow_q, flow_d;
  logic [1:0]           left_q, left_d;
  logic [MAX_FLOWS-1:0] pop_d;
  logic                 gv_d, sop_d, eop_d;
  logic [FW-1:0]        fid_d;
  logic                 stat_inc;

  logic [OW-1:0]        occ [MAX_FLOWS];
  logic [MAX_FLOWS-1:0] expired;

  for (genvar i = 0; i < MAX_FLOWS; i++) begin : g_flow
    logic in_svc;
    logic out_rng;
    logic empty;

    assign occ[i]  = flow_occupancy[i*OW +: OW];
    assign in_svc  = (state_q == S_ISSUE) &&
                     (flow_q == FW'(i));
    assign out_rng = FW'(i) > number_of_flows;
    assign empty   = (occ[i] == '0);

    flow_age_tracker #(
      .TIMEOUT_W (TIMEOUT_W)
    ) u_age (
      .clk           (clk),
      .resetn        (resetn),
      .clr           (in_svc | out_rng | empty),
      .flush_timeout (flush_timeout),
      .expired       (expired[i])
    );
  end

  logic [1:0]    bsz_c;
  logic [2:0]    lines;
  logic [FW-1:0] cur_f;
  logic [FW-1:0] nxt_f;
  logic [OW-1:0] occ_f;
  logic          full_ok;
  logic          flush_ok;

  // A pointer left above a lowered flow count restarts at flow 0.
  assign bsz_c = (32'(l_batch_size) > 2) ? 2'd2
                                         : 2'(l_batch_size);
  assign lines = 3'b001 << bsz_c;
  assign cur_f = (rr_q > number_of_flows) ? '0 : rr_q;
  assign nxt_f = (cur_f == number_of_flows) ? '0
                                            : cur_f + FW'(1);
  assign occ_f = occ[cur_f];

  assign full_ok  = 32'(occ_f) >= 32'(lines);
  assign flush_ok = !full_ok && (occ_f != '0) &&
                    expired[cur_f];

  assign stat_inc = (state_q == S_ISSUE) && grant_sop &&
                    (burst_q == BURST_FLUSH);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    flow_d  = flow_q;
    burst_d = burst_q;
    len_d   = len_q;
    left_d  = left_q;
    pop_d   = '0;
    gv_d    = 1'b0;
    fid_d   = '0;
    cl_d    = eCL_LEN_1;
    sop_d   = 1'b0;
    eop_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_SCAN;
      end
      S_SCAN: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          rr_d = nxt_f;
          if ((full_ok || flush_ok) && !ccip_almost_full) begin
            state_d = S_ISSUE;
            flow_d  = cur_f;
            burst_d = full_ok ? BURST_FULL : BURST_FLUSH;
            len_d   = full_ok ? cl_len_of(bsz_c) : eCL_LEN_1;
            left_d  = full_ok ? 2'(lines - 3'd1) : 2'd0;
            pop_d[cur_f] = 1'b1;
            gv_d    = 1'b1;
            fid_d   = cur_f;
            cl_d    = len_d;
            sop_d   = 1'b1;
            eop_d   = (left_d == 2'd0);
          end
        end
      end
      S_ISSUE: begin
        // Bursts run to completion; start/almost-full are ignored.
        if (grant_eop) begin
          state_d = S_GAP;
        end else begin
          left_d        = left_q - 2'd1;
          pop_d[flow_q] = 1'b1;
          gv_d          = 1'b1;
          fid_d         = flow_q;
          cl_d          = len_q;
          eop_d         = (left_q == 2'd1);
        end
      end
      S_GAP: begin
        // Lets the FIFO count catch up with the last pop.
        state_d = start ? S_SCAN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      rr_q           <= '0;
      flow_q         <= '0;
      burst_q        <= BURST_FULL;
      len_q          <= eCL_LEN_1;
      left_q         <= '0;
      pop_en         <= '0;
      grant_valid    <= 1'b0;
      grant_flow_id  <= '0;
      grant_cl_len   <= '0;
      grant_sop      <= 1'b0;
      grant_eop      <= 1'b0;
      stat_flush_cnt <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      flow_q         <= flow_d;
      burst_q        <= burst_d;
      len_q          <= len_d;
      left_q         <= left_d;
      pop_en         <= pop_d;
      grant_valid    <= gv_d;
      grant_flow_id  <= fid_d;
      grant_cl_len   <= cl_d;
      grant_sop      <= sop_d;
      grant_eop      <= eop_d;
      stat_flush_cnt <= stat_flush_cnt + 32'(stat_inc);
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ccip_tx_flow_scheduler.sv
// Bench for ccip_tx_flow_scheduler: directed scenarios plus random
// traffic, checked against a burst-queue reference model each cycle.
module tb_ccip_tx_flow_scheduler;

  localparam int LF = 1;
  localparam int NF = 2;
  localparam int OW = 4;
  localparam int TW = 16;

  localparam int M_IDLE  = 0;
  localparam int M_SCAN  = 1;
  localparam int M_ISSUE = 2;
  localparam int M_GAP   = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           resetn;
  logic           start;
  logic [LF-1:0]  number_of_flows;
  logic [1:0]     l_batch_size;
  logic [TW-1:0]  flush_timeout;
  logic           ccip_almost_full;
  logic [NF*OW-1:0] flow_occupancy;
  logic [NF-1:0]  pop_en;
  logic           grant_valid;
  logic [LF-1:0]  grant_flow_id;
  logic [1:0]     grant_cl_len;
  logic           grant_sop;
  logic           grant_eop;
  logic           busy;
  logic [31:0]    stat_flush_cnt;

  ccip_tx_flow_scheduler #(
    .LMAX_NUM_OF_FLOWS (LF),
    .LFIFO_DEPTH       (3),
    .TIMEOUT_W         (TW)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .start            (start),
    .number_of_flows  (number_of_flows),
    .l_batch_size     (l_batch_size),
    .flush_timeout    (flush_timeout),
    .ccip_almost_full (ccip_almost_full),
    .flow_occupancy   (flow_occupancy),
    .pop_en           (pop_en),
    .grant_valid      (grant_valid),
    .grant_flow_id    (grant_flow_id),
    .grant_cl_len     (grant_cl_len),
    .grant_sop        (grant_sop),
    .grant_eop        (grant_eop),
    .busy             (busy),
    .stat_flush_cnt   (stat_flush_cnt)
  );

  typedef struct {
    int pop;
    bit v;
    int fid;
    int cl;
    bit sop;
    bit eop;
    bit fl;
  } line_t;

  line_t cur;
  line_t lq[$];
  int mode;
  int ptr;
  int age [NF];
  int stat;
  int occ [NF];
  int pops [NF];
  int sop_fids[$];
  int cyc;
  int last_eop;
  int n_cmp;
  int n_bad;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got=%0d expected=%0d",
               tag, cyc, got, exp);
    end
  endtask

  function automatic line_t no_line();
    line_t l;
    l.pop = 0; l.v = 0; l.fid = 0; l.cl = 0;
    l.sop = 0; l.eop = 0; l.fl = 0;
    return l;
  endfunction

  // CCI-P clLen codes for 1/2/4 lines.
  function automatic int cl_of(input int b);
    return (b == 0) ? 0 : (b == 1) ? 1 : 3;
  endfunction

  // Advances the reference by one clock using the inputs now driven.
  task automatic model_step();
    line_t nx, l;
    int f, b, n, nf, to;
    bit full, fl;
    nf = int'(number_of_flows);
    to = int'(flush_timeout);
    if (!resetn) begin
      mode = M_IDLE; ptr = 0; stat = 0;
      foreach (age[i]) age[i] = 0;
      lq.delete();
      cur = no_line();
      return;
    end
    if (cur.v && cur.sop && cur.fl) stat++;
    nx = no_line();
    case (mode)
      M_IDLE: if (start) mode = M_SCAN;
      M_SCAN: begin
        f = (ptr > nf) ? 0 : ptr;
        b = (int'(l_batch_size) > 2) ? 2 : int'(l_batch_size);
        full = occ[f] >= (1 << b);
        fl = !full && occ[f] >= 1 && to != 0 && age[f] >= to;
        if (!start) begin
          mode = M_IDLE;
        end else begin
          if ((full || fl) && !ccip_almost_full) begin
            n = full ? (1 << b) : 1;
            for (int k = 0; k < n; k++) begin
              l.pop = 1 << f; l.v = 1; l.fid = f;
              l.cl = full ? cl_of(b) : 0;
              l.sop = (k == 0); l.eop = (k == n - 1);
              l.fl = !full;
              lq.push_back(l);
            end
            nx = lq.pop_front();
            mode = M_ISSUE;
          end
          ptr = (f == nf) ? 0 : f + 1;
        end
      end
      M_ISSUE: begin
        if (lq.size() > 0) nx = lq.pop_front();
        else mode = M_GAP;
      end
      default: mode = start ? M_SCAN : M_IDLE;
    endcase
    for (int i = 0; i < NF; i++) begin
      if (occ[i] == 0 || (cur.v && cur.fid == i) || i > nf)
        age[i] = 0;
      else if (age[i] < 65535)
        age[i]++;
    end
    cur = nx;
  endtask

  task automatic cycle();
    int popped [NF];
    for (int i = 0; i < NF; i++)
      flow_occupancy[i*OW +: OW] = OW'(occ[i]);
    for (int i = 0; i < NF; i++) popped[i] = (cur.pop >> i) & 1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NF; i++)
      if (popped[i] != 0 && occ[i] > 0) occ[i]--;
    chk("pop_en", 32'(pop_en), 32'(cur.pop));
    chk("grant_valid", 32'(grant_valid), 32'(cur.v));
    chk("sop", 32'(grant_sop), 32'(cur.sop));
    chk("eop", 32'(grant_eop), 32'(cur.eop));
    chk("busy", 32'(busy), 32'(mode != M_IDLE));
    chk("stat", stat_flush_cnt, 32'(stat));
    if (cur.v) begin
      chk("flow_id", 32'(grant_flow_id), 32'(cur.fid));
      chk("cl_len", 32'(grant_cl_len), 32'(cur.cl));
    end
    for (int i = 0; i < NF; i++) begin
      if (pop_en[i] === 1'b1) begin
        pops[i]++;
        chk("pop_vs_occ", 32'(occ[i] != 0), 1);
      end
    end
    if (grant_sop === 1'b1) begin
      sop_fids.push_back(int'(grant_flow_id));
      if (last_eop >= 0)
        chk("burst_gap", 32'((cyc - last_eop) >= 3), 1);
    end
    if (grant_eop === 1'b1) last_eop = cyc;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic phase(input int nf, input int bsz, input int to,
                       input int o0, input int o1);
    number_of_flows = LF'(nf);
    l_batch_size = 2'(bsz);
    flush_timeout = TW'(to);
    occ[0] = o0;
    occ[1] = o1;
    start = 1'b1;
    ccip_almost_full = 1'b0;
    resetn = 1'b0;
    run(2);
    resetn = 1'b1;
    pops[0] = 0;
    pops[1] = 0;
    sop_fids.delete();
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; last_eop = -100;
    mode = M_IDLE; ptr = 0; stat = 0;
    cur = no_line();
    foreach (age[i]) age[i] = 0;
    foreach (occ[i]) occ[i] = 0;
    resetn = 1'b0; start = 1'b0; ccip_almost_full = 1'b0;
    number_of_flows = '0; l_batch_size = '0; flush_timeout = '0;
    flow_occupancy = '0;
    run(3);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(grant_valid), 0);
    chk("rst_pop", 32'(pop_en), 0);

    phase(1, 1, 0, 2, 0);
    run(20);
    chk("p1_pops0", 32'(pops[0]), 2);
    chk("p1_pops1", 32'(pops[1]), 0);

    phase(1, 2, 0, 8, 8);
    run(60);
    chk("p2_pops0", 32'(pops[0]), 8);
    chk("p2_pops1", 32'(pops[1]), 8);
    chk("p2_bursts", 32'(sop_fids.size()), 4);
    for (int k = 0; k < sop_fids.size() && k < 4; k++)
      chk("p2_order", 32'(sop_fids[k]), 32'(k % 2));

    phase(1, 2, 10, 1, 0);
    run(10);
    chk("p3_noflush_yet", 32'(pops[0]), 0);
    run(30);
    chk("p3_flush_pops", 32'(pops[0]), 1);
    chk("p3_flush_cnt", stat_flush_cnt, 1);
    flush_timeout = '0;
    occ[0] = 1;
    run(60);
    chk("p3_disabled", 32'(pops[0]), 1);

    phase(1, 2, 0, 4, 0);
    ccip_almost_full = 1'b1;
    run(20);
    chk("p4_af_hold", 32'(pops[0]), 0);
    ccip_almost_full = 1'b0;
    run(3);
    ccip_almost_full = 1'b1;
    run(20);
    chk("p4_af_burst", 32'(pops[0]), 4);

    phase(1, 2, 0, 4, 0);
    for (int k = 0; k < 30 && pops[0] < 2; k++) cycle();
    chk("p5_reach_2nd", 32'(pops[0]), 2);
    resetn = 1'b0;
    cycle();
    chk("p5_rst_pop", 32'(pop_en), 0);
    chk("p5_rst_valid", 32'(grant_valid), 0);
    chk("p5_rst_busy", 32'(busy), 0);
    chk("p5_rst_stat", stat_flush_cnt, 0);
    resetn = 1'b1;

    phase(0, 2, 5, 0, 4);
    run(30);
    chk("p6_masked", 32'(pops[1]), 0);
    number_of_flows = 1'b1;
    run(30);
    chk("p6_enabled", 32'(pops[1]), 4);

    phase(1, 1, 6, 0, 0);
    for (int k = 0; k < 3000; k++) begin
      if (start) start = ($urandom_range(0, 49) != 0);
      else start = ($urandom_range(0, 3) == 0);
      ccip_almost_full = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 63) == 0)
        l_batch_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 127) == 0)
        number_of_flows = LF'($urandom_range(0, 1));
      if ($urandom_range(0, 255) == 0)
        flush_timeout = ($urandom_range(0, 3) == 0) ? '0
                      : TW'($urandom_range(3, 20));
      resetn = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < NF; i++)
        if (occ[i] < 8 && $urandom_range(0, 5) == 0) occ[i]++;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccip_tx_flow_scheduler.md
Name: ccip_tx_flow_scheduler

Overview:
Round-robin batch scheduler for the CPU-NIC TX path. It watches per-flow FIFO occupancy and picks one flow at a time, then issues a burst of pop strobes to that flow's FIFO. A burst is either a full CCI-P batch (1/2/4 lines) or, after a per-flow age timeout, a single-line flush. It sits between the flow FIFOs and the request-queue pop/CCI-P write stage, and gates new bursts on CCI-P TX almost-full.

Parameters:
LMAX_NUM_OF_FLOWS, 1, log2 of max flows; MAX_FLOWS = 2**LMAX_NUM_OF_FLOWS
LFIFO_DEPTH, 3, log2 flow FIFO depth; occupancy width LFIFO_DEPTH+1
LMAX_CCIP_BATCH, 2, width of l_batch_size
TIMEOUT_W, 16, width of age counters and flush_timeout

Ports:
clk  in  1  sole clock
resetn  in  1  reset, synchronous, active-low
start  in  1  enable scheduling
number_of_flows  in  LMAX_NUM_OF_FLOWS  highest active flow index
l_batch_size  in  LMAX_CCIP_BATCH  log2 batch size; values >2 clamp to 2
flush_timeout  in  TIMEOUT_W  age threshold in cycles; 0 disables flush
ccip_almost_full  in  1  CCI-P c1 TX almost-full
flow_occupancy  in  MAX_FLOWS*(LFIFO_DEPTH+1)  packed per-flow FIFO fill count, flow 0 in LSBs
pop_en  out  MAX_FLOWS  one-hot pop strobe to flow FIFOs
grant_valid  out  1  a burst line is issued this cycle
grant_flow_id  out  LMAX_NUM_OF_FLOWS  flow being served
grant_cl_len  out  2  t_ccip_clLen of the current burst
grant_sop  out  1  first line of burst
grant_eop  out  1  last line of burst
busy  out  1  state != S_IDLE
stat_flush_cnt  out  32  count of timeout flush bursts, wraps

Behaviour:
- Reset (resetn=0 at posedge): all outputs 0, state S_IDLE, rr pointer 0, ages 0, stat 0. Reset mid-burst aborts the burst; pop_en is 0 from the next edge.
- States:
  - S_IDLE: go to S_SCAN when start=1.
  - S_SCAN: evaluates flow f = rr pointer, one flow per cycle.
    - Full-batch eligible: occ[f] >= 2**bsz.
    - Flush eligible: not full-batch eligible, occ[f] >= 1, flush_timeout != 0, and age[f] >= flush_timeout.
    - If either is eligible and ccip_almost_full=0: latch f, length (bsz or 0), and burst type; go to S_ISSUE.
    - Else advance pointer: f == number_of_flows -> 0, else f+1.
    - If start=0: go to S_IDLE.
  - S_ISSUE: one line per cycle for the latched length L.
    - Registered outputs: pop_en[f]=1, grant_valid=1, grant_flow_id=f, grant_cl_len=eCL_LEN_L, sop on the first line, eop on the last.
    - After the eop line, go to S_GAP. The pointer advances past f.
    - A started burst always completes, regardless of ccip_almost_full or start.
  - S_GAP: one cycle, because FIFO occupancy lags a pop by one cycle. Then go to S_SCAN if start=1, else S_IDLE.
- Latency: eligible in S_SCAN at cycle N -> first pop_en/grant at cycle N+1. Back-to-back bursts are separated by at least 2 idle cycles (GAP + SCAN).
- Age: per flow, updated each cycle.
  - Cleared when occ=0, when the flow is in service, or when its index > number_of_flows.
  - Otherwise incremented, saturating at all-ones.
- Config: number_of_flows and l_batch_size are sampled only in S_SCAN; they are stable within a burst. Flows above number_of_flows are never granted. If the pointer exceeds a newly lowered number_of_flows, it wraps to 0 on the next SCAN.
- Flush bursts are always cl_len=1. stat_flush_cnt increments on the sop line of each flush burst.
- The block never pops more lines than the occupancy sampled in S_SCAN.

Decomposition:
- Shared package nic_defs:
  - LMAX_CCIP_BATCH
  - enum TxSchedState {S_IDLE, S_SCAN, S_ISSUE, S_GAP}
  - typedef TxBurstType {BURST_FULL, BURST_FLUSH}
  - occupancy width function
- Sub-module flow_age_tracker: one saturating TIMEOUT_W counter per flow, with clear/inc/expired logic. Instantiated MAX_FLOWS times via generate.

Test Plan:
- bsz=1, flows=1, occ0=2, occ1=0, af=0, start -> at SCAN+1: pop_en=01 for 2 cycles, cl_len=eCL_LEN_2, sop then eop, flow_id=0; the next burst starts at least 2 cycles later.
- bsz=2, occ0=4, occ1=4 -> bursts alternate: flow0 then flow1, each 4 pops with eCL_LEN_4; no flow is served twice in a row.
- bsz=2, occ0=1, flush_timeout=10 -> no grant for 10 cycles; then 1 pop, cl_len=eCL_LEN_1, stat_flush_cnt=1; flush_timeout=0 -> no grant ever.
- ccip_almost_full=1 with occ0=4 -> no grant; deassert -> burst starts 1-2 cycles later. Assert af during a burst -> all 4 pops still complete.
- resetn=0 on 2nd pop of a 4-line burst -> pop_en=0, grant_valid=0, busy=0 next cycle; stat_flush_cnt=0.
- number_of_flows=0 with occ1=4 -> flow1 is never popped; set number_of_flows=1 -> flow1 is served.
